// File: rtl/sonar_scheduler_if.sv
// Signal bundle between the sonar scheduler and its environment: the per-channel
// start/done/result handshake, the sample strobe and status flags, and the
// memory-mapped read port. The scheduler takes the master side.
interface sonar_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
);
   logic [NUM_CH-1:0]    enable_mask;
   logic [NUM_CH-1:0]    start;
   logic [NUM_CH-1:0]    done;
   logic [NUM_CH*16-1:0] range_in;
   logic                 sample_valid;
   logic [CH_W-1:0]      sample_ch;
   logic [NUM_CH-1:0]    chan_valid;
   logic [NUM_CH-1:0]    timeout_flag;
   logic [CH_W-1:0]      rd_addr;
   logic [15:0]          rd_data;

   modport master (
      input  enable_mask, done, range_in, rd_addr,
      output start, sample_valid, sample_ch, chan_valid, timeout_flag, rd_data
   );

   modport slave (
      output enable_mask, done, range_in, rd_addr,
      input  start, sample_valid, sample_ch, chan_valid, timeout_flag, rd_data
   );
endinterface

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler for ultrasonic ranging channels sharing one acoustic
// space. One channel is fired at a time through a start/done handshake, a guard
// gap follows every store, and each channel's last 16-bit result is kept in a
// register bank served by a registered read port.
// Optional feature macro: SONAR_TIMEOUT_EN -- bounds WAIT_DONE to TIMEOUT_CYCLES
// and stores 16'hFFFF with a per-channel timeout flag when a channel stays silent.
module sonar_scheduler #(
   parameter int NUM_CH         = 4,
   parameter int CH_W           = 2,
   parameter int GUARD_CYCLES   = 3000000,
   parameter int GUARD_W        = 22,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int TIMEOUT_W      = 22
) (
   input logic               clk,
   input logic               reset,
   sonar_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      FIRE,
      WAIT_DONE,
      STORE,
      GUARD
   } state_t;

   state_t              state;
   logic [CH_W-1:0]     ptr;
   logic [GUARD_W-1:0]  guard_cnt;
   logic [NUM_CH-1:0]   start_q;
   logic                sample_valid_q;
   logic [CH_W-1:0]     sample_ch_q;
   logic [NUM_CH-1:0]   chan_valid_q;
   logic [15:0]         rd_data_q;

   logic [15:0]         range_p0;
   logic [15:0]         bank [NUM_CH];
   logic [15:0]         range_slice [NUM_CH];
   logic [15:0]         store_val;

   logic                sel_found;
   logic [CH_W-1:0]     sel_idx;
   logic [CH_W-1:0]     cand;
   logic                done_hit;
   logic                rd_in_range;

`ifdef SONAR_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] to_cnt;
   logic                 to_hit;
   logic                 to_expire;
   logic [NUM_CH-1:0]    timeout_flag_q;

   assign to_expire          = (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
   assign store_val          = to_hit ? 16'hFFFF : range_p0;
   assign bus.timeout_flag   = timeout_flag_q;
`else
   // Timeout configuration is not used when the timeout feature is left out.
   wire unused_timeout_cfg = (TIMEOUT_CYCLES > 0) && (TIMEOUT_W > 0);

   assign store_val          = range_p0;
   assign bus.timeout_flag   = '0;
`endif

   assign done_hit     = bus.done[ptr];
   assign rd_in_range  = (32'(bus.rd_addr) < NUM_CH);

   assign bus.start        = start_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.sample_ch    = sample_ch_q;
   assign bus.chan_valid   = chan_valid_q;
   assign bus.rd_data      = rd_data_q;

   // Split the packed result bus into per-channel 16-bit words.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         range_slice[i] = bus.range_in[16*i +: 16];
      end
   end

   // Round-robin search: scan from farthest to nearest so the nearest enabled
   // channel after ptr wins, with ptr itself as the last resort.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = ptr;
      cand      = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         cand = CH_W'((int'(ptr) + k) % NUM_CH);
         if (bus.enable_mask[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Scheduler FSM with registered start, sample strobe and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         ptr            <= CH_W'(NUM_CH - 1);
         guard_cnt      <= '0;
         start_q        <= '0;
         sample_valid_q <= 1'b0;
         sample_ch_q    <= '0;
         chan_valid_q   <= '0;
`ifdef SONAR_TIMEOUT_EN
         to_cnt         <= '0;
         to_hit         <= 1'b0;
         timeout_flag_q <= '0;
`endif
      end else begin
         start_q        <= '0;
         sample_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.enable_mask != '0) begin
                  state <= SELECT;
               end
            end
            SELECT: begin
               if (sel_found) begin
                  ptr     <= sel_idx;
                  start_q <= NUM_CH'(1) << sel_idx;
                  state   <= FIRE;
               end else begin
                  state <= IDLE;
               end
            end
            FIRE: begin
`ifdef SONAR_TIMEOUT_EN
               to_cnt <= '0;
               to_hit <= 1'b0;
`endif
               state  <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // A done arriving together with the timeout still counts as good.
               if (done_hit) begin
                  state <= STORE;
               end
`ifdef SONAR_TIMEOUT_EN
               else if (to_expire) begin
                  to_hit <= 1'b1;
                  state  <= STORE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            STORE: begin
               sample_valid_q    <= 1'b1;
               sample_ch_q       <= ptr;
               chan_valid_q[ptr] <= 1'b1;
`ifdef SONAR_TIMEOUT_EN
               timeout_flag_q[ptr] <= to_hit;
`endif
               guard_cnt         <= '0;
               state             <= GUARD;
            end
            GUARD: begin
               if (guard_cnt == GUARD_W'(GUARD_CYCLES - 1)) begin
                  state <= SELECT;
               end else begin
                  guard_cnt <= guard_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---- stage p0: capture the selected channel's result on its done strobe
   always_ff @(posedge clk) begin
      if (state == WAIT_DONE && done_hit) begin
         range_p0 <= range_slice[ptr];
      end
   end

   // ---- bank write: commit the captured (or timeout) value in STORE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            bank[i] <= '0;
         end
      end else if (state == STORE) begin
         bank[ptr] <= store_val;
      end
   end

   // Registered read port; a same-cycle store is seen one read later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_in_range) begin
         rd_data_q <= bank[bus.rd_addr];
      end else begin
         rd_data_q <= '0;
      end
   end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Bench for sonar_scheduler: channel responders and a round-robin reference
// model (pointer, result bank, sticky valid and timeout flags) live here.
module tb_sonar_scheduler;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam int G      = 20;
   localparam int T      = 40;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   sonar_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

   sonar_scheduler #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .GUARD_CYCLES(G), .GUARD_W(8),
      .TIMEOUT_CYCLES(T), .TIMEOUT_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   int                m_ptr;
   logic [15:0]       m_bank [NUM_CH];
   logic [NUM_CH-1:0] m_cv;
   logic [NUM_CH-1:0] m_tf;

   function automatic int model_next(input logic [NUM_CH-1:0] mask);
      for (int k = 1; k <= NUM_CH; k++) begin
         if (mask[(m_ptr + k) % NUM_CH]) return (m_ptr + k) % NUM_CH;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = NUM_CH - 1;
      for (int i = 0; i < NUM_CH; i++) m_bank[i] = 16'h0000;
      m_cv = '0;
      m_tf = '0;
   endtask

   task automatic drive_reset();
      bus.enable_mask = '0;
      bus.done        = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic wait_start(output int ch, output int at);
      ch = -1;
      at = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.start != '0) begin
            at = cyc;
            for (int i = 0; i < NUM_CH; i++) if (bus.start[i]) ch = i;
            checks++;
            if ($countones(bus.start) != 1) begin
               errors++;
               $display("FAIL start_onehot: start=%b, required exactly one bit set", bus.start);
            end
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL start_timeout: no start within 200 cycles, required a start pulse");
   endtask

   // Called at the negedge where start was seen; done arrives lat cycles later.
   task automatic finish_meas(input int ch, input int lat, input logic [15:0] val);
      logic spurious;
      if (ch < 0) return;
      spurious = 1'b0;
      repeat (lat) begin
         @(negedge clk);
         if (bus.sample_valid || bus.start != '0) spurious = 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) bus.range_in[16*i +: 16] = 16'($urandom);
      bus.range_in[16*ch +: 16] = val;
      bus.done     = '0;
      bus.done[ch] = 1'b1;
      @(negedge clk);
      bus.done = '0;
      checks++;
      if (bus.sample_valid !== 1'b0 || spurious) begin
         errors++;
         $display("FAIL early_activity ch%0d: sample_valid=%b spurious=%b, required 0 and 0",
                  ch, bus.sample_valid, spurious);
      end
      @(negedge clk);
      m_bank[ch] = val;
      m_cv[ch]   = 1'b1;
      m_tf[ch]   = 1'b0;
      m_ptr      = ch;
      checks++;
      if (bus.sample_valid !== 1'b1 || bus.sample_ch !== CH_W'(ch)) begin
         errors++;
         $display("FAIL sample ch%0d: sample_valid=%b sample_ch=%0d, required 1 and %0d",
                  ch, bus.sample_valid, bus.sample_ch, ch);
      end
      checks++;
      if (bus.chan_valid !== m_cv || bus.timeout_flag !== m_tf) begin
         errors++;
         $display("FAIL flags ch%0d: chan_valid=%b timeout_flag=%b, required %b and %b",
                  ch, bus.chan_valid, bus.timeout_flag, m_cv, m_tf);
      end
   endtask

   task automatic check_bank();
      for (int i = 0; i < NUM_CH; i++) begin
         @(negedge clk);
         bus.rd_addr = CH_W'(i);
         @(negedge clk);
         checks++;
         if (bus.rd_data !== m_bank[i]) begin
            errors++;
            $display("FAIL bank_read[%0d]: rd_data=%h, required %h", i, bus.rd_data, m_bank[i]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.start, bus.sample_valid, bus.sample_ch, bus.chan_valid,
           bus.timeout_flag, bus.rd_data} !== '0) begin
         errors++;
         $display("FAIL reset_values: start=%b sv=%b sch=%0d cv=%b tf=%b rd=%h, required all 0",
                  bus.start, bus.sample_valid, bus.sample_ch, bus.chan_valid,
                  bus.timeout_flag, bus.rd_data);
      end
      reset = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      checks++;
      if (bus.start !== '0 || bus.sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_mask: start=%b sample_valid=%b, required 0 and 0",
                  bus.start, bus.sample_valid);
      end
      check_bank();
   endtask

   task automatic test_round_robin();
      int ch, at, exp;
      bus.enable_mask = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp = model_next(bus.enable_mask);
         wait_start(ch, at);
         checks++;
         if (ch != exp) begin
            errors++;
            $display("FAIL rr_order[%0d]: fired ch%0d, required ch%0d", n, ch, exp);
         end
         finish_meas(ch, 10, 16'h0100 + 16'(ch));
      end
      bus.enable_mask = '0;
      check_bank();
   endtask

   task automatic test_single_channel();
      int ch, t1, t2;
      bus.enable_mask = 4'b0100;
      wait_start(ch, t1);
      checks++;
      if (ch != 2) begin
         errors++;
         $display("FAIL single_first: fired ch%0d, required ch2", ch);
      end
      finish_meas(ch, 10, 16'($urandom));
      wait_start(ch, t2);
      checks++;
      if (ch != 2 || (t2 - t1) != 10 + G + 3) begin
         errors++;
         $display("FAIL single_period: ch%0d period=%0d, required ch2 period=%0d",
                  ch, t2 - t1, 10 + G + 3);
      end
      finish_meas(ch, 10, 16'($urandom));
      bus.enable_mask = '0;
      check_bank();
   endtask

   task automatic test_mask_change();
      int ch, at;
      bus.enable_mask = 4'b0010;
      wait_start(ch, at);
      checks++;
      if (ch != 1) begin
         errors++;
         $display("FAIL maskchg_first: fired ch%0d, required ch1", ch);
      end
      bus.enable_mask = 4'b1010;
      @(negedge clk);
      bus.enable_mask = 4'b0001;
      finish_meas(ch, 4, 16'($urandom));
      wait_start(ch, at);
      checks++;
      if (ch != 0) begin
         errors++;
         $display("FAIL maskchg_next: fired ch%0d, required ch0", ch);
      end
      finish_meas(ch, 3, 16'($urandom));
      bus.enable_mask = '0;
      check_bank();
   endtask

   task automatic test_foreign_done();
      int ch, at;
      logic quiet;
      logic [15:0] old_v, new_v;
      bus.enable_mask = 4'b0010;
      wait_start(ch, at);
      checks++;
      if (ch != 1) begin
         errors++;
         $display("FAIL foreign_first: fired ch%0d, required ch1", ch);
      end
      // done during the FIRE cycle, then a done on another channel: both ignored
      bus.range_in = {NUM_CH{16'hBAD0}};
      bus.done = 4'b0010;
      @(negedge clk);
      bus.done = 4'b1000;
      @(negedge clk);
      bus.done = '0;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.sample_valid || bus.start != '0) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL foreign_ignored: activity seen after ineligible done, required none");
      end
      old_v = m_bank[1];
      new_v = 16'($urandom);
      bus.range_in[16 +: 16] = new_v;
      bus.done = 4'b0010;
      @(negedge clk);
      bus.done    = '0;
      bus.rd_addr = 2'd1;
      @(negedge clk);
      checks++;
      if (bus.rd_data !== old_v || bus.sample_valid !== 1'b1 || bus.sample_ch !== 2'd1) begin
         errors++;
         $display("FAIL collide_old: rd=%h sv=%b sch=%0d, required %h 1 1",
                  bus.rd_data, bus.sample_valid, bus.sample_ch, old_v);
      end
      m_bank[1] = new_v;
      m_cv[1]   = 1'b1;
      m_tf[1]   = 1'b0;
      m_ptr     = 1;
      @(negedge clk);
      checks++;
      if (bus.rd_data !== new_v) begin
         errors++;
         $display("FAIL collide_new: rd_data=%h, required %h", bus.rd_data, new_v);
      end
      bus.enable_mask = '0;
      check_bank();
   endtask

   task automatic test_random();
      int ch, at, exp;
      for (int n = 0; n < 12; n++) begin
         bus.enable_mask = 4'($urandom_range(1, 15));
         exp = model_next(bus.enable_mask);
         wait_start(ch, at);
         checks++;
         if (ch != exp) begin
            errors++;
            $display("FAIL random_order[%0d]: mask=%b fired ch%0d, required ch%0d",
                     n, bus.enable_mask, ch, exp);
         end
         finish_meas(ch, $urandom_range(1, 12), 16'($urandom));
      end
      bus.enable_mask = '0;
      check_bank();
   endtask

   task automatic test_timeout();
      int ch, at, k_hit;
      bus.enable_mask = 4'b0100;
      wait_start(ch, at);
      checks++;
      if (ch != 2) begin
         errors++;
         $display("FAIL timeout_first: fired ch%0d, required ch2", ch);
      end
`ifdef SONAR_TIMEOUT_EN
      k_hit = 0;
      for (int k = 1; k <= T + 20; k++) begin
         @(negedge clk);
         if (bus.sample_valid) begin
            k_hit = k;
            break;
         end
      end
      m_bank[2] = 16'hFFFF;
      m_cv[2]   = 1'b1;
      m_tf[2]   = 1'b1;
      m_ptr     = 2;
      checks++;
      if (k_hit != T + 2 || bus.sample_ch !== 2'd2) begin
         errors++;
         $display("FAIL timeout_store: sample after %0d cycles on ch%0d, required %0d on ch2",
                  k_hit, bus.sample_ch, T + 2);
      end
      checks++;
      if (bus.timeout_flag !== m_tf || bus.chan_valid !== m_cv) begin
         errors++;
         $display("FAIL timeout_flags: tf=%b cv=%b, required %b %b",
                  bus.timeout_flag, bus.chan_valid, m_tf, m_cv);
      end
      check_bank();
      wait_start(ch, at);
      finish_meas(ch, 6, 16'($urandom));
      bus.enable_mask = '0;
      check_bank();
`else
      k_hit = 0;
      bus.enable_mask = '0;
      for (int k = 1; k <= 3 * T; k++) begin
         @(negedge clk);
         if (bus.sample_valid || bus.start != '0) k_hit = k;
      end
      checks++;
      if (k_hit != 0 || bus.timeout_flag !== '0) begin
         errors++;
         $display("FAIL wait_forever: activity at cycle %0d tf=%b, required none and 0",
                  k_hit, bus.timeout_flag);
      end
`endif
   endtask

   task automatic test_reset_midop();
      int ch, at;
      drive_reset();
      bus.rd_addr     = 2'd0;
      bus.enable_mask = 4'b1111;
      wait_start(ch, at);
      finish_meas(ch, 5, 16'hA5A5);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({bus.start, bus.sample_valid, bus.sample_ch, bus.chan_valid,
           bus.timeout_flag, bus.rd_data} !== '0) begin
         errors++;
         $display("FAIL reset_guard: cv=%b rd=%h sv=%b, required all outputs 0",
                  bus.chan_valid, bus.rd_data, bus.sample_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      wait_start(ch, at);
      checks++;
      if (ch != 0) begin
         errors++;
         $display("FAIL reset_guard_refire: fired ch%0d, required ch0", ch);
      end
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({bus.start, bus.sample_valid, bus.sample_ch, bus.chan_valid,
           bus.timeout_flag, bus.rd_data} !== '0) begin
         errors++;
         $display("FAIL reset_wait: start=%b sv=%b cv=%b, required all outputs 0",
                  bus.start, bus.sample_valid, bus.chan_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      wait_start(ch, at);
      checks++;
      if (ch != 0) begin
         errors++;
         $display("FAIL reset_wait_refire: fired ch%0d, required ch0", ch);
      end
      finish_meas(ch, 4, 16'($urandom));
      bus.enable_mask = '0;
      check_bank();
   endtask

   initial begin
      bus.enable_mask = '0;
      bus.done        = '0;
      bus.range_in    = '0;
      bus.rd_addr     = '0;
      model_reset();
      test_reset();
      test_round_robin();
      test_single_channel();
      test_mask_change();
      test_foreign_done();
      test_random();
      test_timeout();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
